// File: rtl/bp_perceptron_pkg.sv
// Shared parameter defaults, FSM encoding and width helpers for the perceptron branch predictor.
package bp_perceptron_pkg;

  localparam int PERCEPTRON_NUMBER_DEF = 64;
  localparam int WEIGHT_NUMBER_DEF     = 65;
  localparam int WIDTH_DEF             = 8;
  localparam int HISTORY_SIZE_DEF      = 64;
  localparam int LANES_DEF             = 8;

  // One extra bit beyond the worst-case magnitude keeps the signed sum overflow-free.
  function automatic int calcSumWidth(input int width, input int weightNumber);
    return width + $clog2(weightNumber) + 1;
  endfunction

  function automatic int calcNChunk(input int weightNumber, input int lanes);
    return (weightNumber + lanes - 1) / lanes;
  endfunction

  localparam int SUM_WIDTH = calcSumWidth(WIDTH_DEF, WEIGHT_NUMBER_DEF);
  localparam int NCHUNK    = calcNChunk(WEIGHT_NUMBER_DEF, LANES_DEF);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_t;

endpackage

// File: rtl/perceptron_chunk_adder.sv
// Combinational partial sum of one chunk: each weight is added when its history bit
// (or the bias flag on lane 0) is set, otherwise subtracted.
module perceptron_chunk_adder
  import bp_perceptron_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LANES = LANES_DEF,
  parameter int SUM_W = calcSumWidth(WIDTH_DEF, WEIGHT_NUMBER_DEF)
)(
  input  logic [LANES-1:0][WIDTH-1:0] i_weights,
  input  logic [LANES-1:0]            i_history,
  input  logic                        i_bias,
  output logic signed [SUM_W-1:0]     o_partial
);

  logic signed [SUM_W-1:0] w_ext;

  always_comb begin
    o_partial = '0;
    w_ext     = '0;
    for (int l = 0; l < LANES; l++) begin
      w_ext = SUM_W'(signed'(i_weights[l]));
      if (i_history[l] || (i_bias && l == 0)) o_partial = o_partial + w_ext;
      else                                   o_partial = o_partial - w_ext;
    end
  end

endmodule

// File: rtl/perceptron_predictor.sv
// Multi-cycle perceptron branch predictor: one weight row is summed LANES weights per
// cycle against a history snapshot, and the result is held until the consumer takes it.
module perceptron_predictor
  import bp_perceptron_pkg::*;
#(
  parameter int PERCEPTRON_NUMBER = PERCEPTRON_NUMBER_DEF,
  parameter int WEIGHT_NUMBER     = WEIGHT_NUMBER_DEF,
  parameter int WIDTH             = WIDTH_DEF,
  parameter int HISTORY_SIZE      = HISTORY_SIZE_DEF,
  parameter int LANES             = LANES_DEF
)(
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 i_req_valid,
  input  logic [31:0]                                          i_req_pc,
  output logic                                                 o_req_ready,
  output logic                                                 o_pred_valid,
  input  logic                                                 i_pred_ready,
  output logic                                                 o_pred_taken,
  output logic signed [calcSumWidth(WIDTH, WEIGHT_NUMBER)-1:0] o_pred_sum,
  output logic [$clog2(PERCEPTRON_NUMBER)-1:0]                 o_pred_index,
  output logic [HISTORY_SIZE-1:0]                              o_pred_history,
  input  logic                                                 i_res_valid,
  input  logic                                                 i_res_taken,
  input  logic                                                 i_upd_valid,
  input  logic [$clog2(PERCEPTRON_NUMBER)-1:0]                 i_upd_index,
  input  logic [WEIGHT_NUMBER-1:0][WIDTH-1:0]                  i_upd_weights
);

  localparam int IDX_W   = $clog2(PERCEPTRON_NUMBER);
  localparam int SUM_W   = calcSumWidth(WIDTH, WEIGHT_NUMBER);
  localparam int N_CHUNK = calcNChunk(WEIGHT_NUMBER, LANES);
  localparam int CHUNK_W = $clog2(N_CHUNK + 1);
  localparam int PAD     = N_CHUNK * LANES;

  state_t                              r_state, w_next_state;
  logic [WEIGHT_NUMBER-1:0][WIDTH-1:0] r_weights [PERCEPTRON_NUMBER];
  logic [HISTORY_SIZE-1:0]             r_ghr, r_snap, r_pred_history;
  logic [IDX_W-1:0]                    r_index, r_pred_index;
  logic [CHUNK_W-1:0]                  r_chunk;
  logic signed [SUM_W-1:0]             r_sum, r_pred_sum, w_partial;
  logic                                r_pred_taken;
  logic [WEIGHT_NUMBER-1:0][WIDTH-1:0] w_row;
  logic [PAD-1:0][WIDTH-1:0]           w_pad;
  logic [PAD-1:0]                      w_hpad;
  logic [LANES-1:0][WIDTH-1:0]         w_chunk_w;
  logic [LANES-1:0]                    w_chunk_h;
  logic                                w_accept, w_restart, w_last, w_unused_pc;

  assign w_accept    = (r_state == IDLE) && i_req_valid;
  assign w_restart   = (r_state == ACCUM) && i_upd_valid && (i_upd_index == r_index);
  assign w_last      = (r_chunk == CHUNK_W'(N_CHUNK));
  assign w_unused_pc = ^{i_req_pc[31:IDX_W+2], i_req_pc[1:0]};
  assign w_row       = r_weights[r_index];

  // Pad the row and the snapshot to whole chunks; weight k pairs with history bit k-1.
  for (genvar k = 0; k < PAD; k++) begin : g_pad
    if (k < WEIGHT_NUMBER) begin : g_w
      assign w_pad[k] = w_row[k];
    end else begin : g_wz
      assign w_pad[k] = '0;
    end
    if (k >= 1 && k <= HISTORY_SIZE) begin : g_h
      assign w_hpad[k] = r_snap[k-1];
    end else begin : g_hz
      assign w_hpad[k] = 1'b0;
    end
  end

  always_comb begin
    w_chunk_w = '0;
    w_chunk_h = '0;
    for (int c = 0; c < N_CHUNK; c++) begin
      if (r_chunk == CHUNK_W'(c)) begin
        w_chunk_w = w_pad[c*LANES +: LANES];
        w_chunk_h = w_hpad[c*LANES +: LANES];
      end
    end
  end

  perceptron_chunk_adder #(
    .WIDTH (WIDTH),
    .LANES (LANES),
    .SUM_W (SUM_W)
  ) u_adder (
    .i_weights (w_chunk_w),
    .i_history (w_chunk_h),
    .i_bias    (r_chunk == '0),
    .o_partial (w_partial)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = ACCUM;
      ACCUM:   if (!w_restart && w_last) w_next_state = DONE;
      DONE:    if (i_pred_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    o_req_ready  = (r_state == IDLE);
    o_pred_valid = (r_state == DONE);
  end

  // The counter runs one past the last chunk so the result is published a cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ghr          <= '0;
      r_snap         <= '0;
      r_index        <= '0;
      r_chunk        <= '0;
      r_sum          <= '0;
      r_pred_sum     <= '0;
      r_pred_taken   <= 1'b0;
      r_pred_index   <= '0;
      r_pred_history <= '0;
    end else begin
      if (i_res_valid) r_ghr <= {r_ghr[HISTORY_SIZE-2:0], i_res_taken};
      if (w_accept) begin
        r_index <= i_req_pc[IDX_W+1:2];
        r_snap  <= r_ghr;
        r_sum   <= '0;
        r_chunk <= '0;
      end else if (r_state == ACCUM) begin
        if (w_restart) begin
          r_sum   <= '0;
          r_chunk <= '0;
        end else if (w_last) begin
          r_pred_sum     <= r_sum;
          r_pred_taken   <= ~r_sum[SUM_W-1];
          r_pred_index   <= r_index;
          r_pred_history <= r_snap;
        end else begin
          r_sum   <= r_sum + w_partial;
          r_chunk <= r_chunk + CHUNK_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int p = 0; p < PERCEPTRON_NUMBER; p++) r_weights[p] <= '0;
    end else if (i_upd_valid) begin
      r_weights[i_upd_index] <= i_upd_weights;
    end
  end

  assign o_pred_sum     = r_pred_sum;
  assign o_pred_taken   = r_pred_taken;
  assign o_pred_index   = r_pred_index;
  assign o_pred_history = r_pred_history;

endmodule

// File: tb/tb_perceptron_predictor.sv
// Scoreboard bench for perceptron_predictor: expected predictions come from a bench-side
// weight/history model and are compared when the DUT raises pred_valid.
module tb_perceptron_predictor;
  import bp_perceptron_pkg::*;

  logic                        clk = 1'b0;
  logic                        rst_n;
  logic                        i_req_valid;
  logic [31:0]                 i_req_pc;
  logic                        o_req_ready;
  logic                        o_pred_valid;
  logic                        i_pred_ready;
  logic                        o_pred_taken;
  logic signed [SUM_WIDTH-1:0] o_pred_sum;
  logic [5:0]                  o_pred_index;
  logic [63:0]                 o_pred_history;
  logic                        i_res_valid;
  logic                        i_res_taken;
  logic                        i_upd_valid;
  logic [5:0]                  i_upd_index;
  logic [64:0][7:0]            i_upd_weights;

  typedef struct {
    longint      sum;
    bit          taken;
    logic [5:0]  idx;
    logic [63:0] hist;
  } exp_t;

  exp_t        expQ[$];
  int          mWeights [64][65];
  logic [63:0] mGhr;
  int          rowBuf [65];
  int          checks = 0;
  int          errors = 0;
  bit          seenValid;

  perceptron_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (i_req_valid),
    .i_req_pc       (i_req_pc),
    .o_req_ready    (o_req_ready),
    .o_pred_valid   (o_pred_valid),
    .i_pred_ready   (i_pred_ready),
    .o_pred_taken   (o_pred_taken),
    .o_pred_sum     (o_pred_sum),
    .o_pred_index   (o_pred_index),
    .o_pred_history (o_pred_history),
    .i_res_valid    (i_res_valid),
    .i_res_taken    (i_res_taken),
    .i_upd_valid    (i_upd_valid),
    .i_upd_index    (i_upd_index),
    .i_upd_weights  (i_upd_weights)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic longint modelSum(input logic [5:0] idx, input logic [63:0] h);
    longint s;
    s = mWeights[idx][0];
    for (int i = 1; i <= 64; i++) s += h[i-1] ? mWeights[idx][i] : -mWeights[idx][i];
    return s;
  endfunction

  task automatic loadUpdWeights();
    for (int k = 0; k < 65; k++) i_upd_weights[k] = 8'(rowBuf[k]);
  endtask

  task automatic writeRow(input logic [5:0] idx);
    @(negedge clk);
    i_upd_valid = 1'b1;
    i_upd_index = idx;
    loadUpdWeights();
    for (int k = 0; k < 65; k++) mWeights[idx][k] = rowBuf[k];
    @(posedge clk);
    #1 i_upd_valid = 1'b0;
  endtask

  task automatic setGhr(input logic [63:0] pattern);
    for (int i = 63; i >= 0; i--) begin
      @(negedge clk);
      i_res_valid = 1'b1;
      i_res_taken = pattern[i];
      mGhr = {mGhr[62:0], pattern[i]};
      @(posedge clk);
      #1 i_res_valid = 1'b0;
    end
  endtask

  // Drives one request (optionally with a resolved branch on the same edge) and queues its expectation.
  task automatic applyStimulus(input logic [31:0] pc, input bit resValid, input bit resTaken, input bit doPush);
    exp_t e;
    @(negedge clk);
    checkOutput("reqReady", o_req_ready, 1);
    i_req_valid = 1'b1;
    i_req_pc    = pc;
    i_res_valid = resValid;
    i_res_taken = resTaken;
    e.idx   = pc[7:2];
    e.hist  = mGhr;
    e.sum   = modelSum(e.idx, mGhr);
    e.taken = (e.sum >= 0);
    if (doPush) expQ.push_back(e);
    @(posedge clk);
    #1 i_req_valid = 1'b0;
    i_res_valid = 1'b0;
    if (resValid) mGhr = {mGhr[62:0], resTaken};
  endtask

  task automatic collectPrediction(input int expEdges, input int injEdge, input int injVal, input int holdCycles);
    int   edges;
    bit   got;
    exp_t e;
    edges = 0;
    got   = 1'b0;
    while (edges < 40) begin
      @(negedge clk);
      if (o_pred_valid) begin
        got = 1'b1;
        break;
      end
      if (edges == injEdge && expQ.size() > 0) begin
        e = expQ.pop_back();
        for (int k = 0; k < 65; k++) begin
          rowBuf[k] = injVal;
          mWeights[e.idx][k] = injVal;
        end
        i_upd_valid = 1'b1;
        i_upd_index = e.idx;
        loadUpdWeights();
        e.sum   = modelSum(e.idx, e.hist);
        e.taken = (e.sum >= 0);
        expQ.push_back(e);
      end
      @(posedge clk);
      #1 i_upd_valid = 1'b0;
      edges++;
    end
    checkOutput("predLatency", got ? edges : -1, expEdges);
    if (expQ.size() == 0) begin
      checkOutput("scoreboardEmpty", 1, 0);
      return;
    end
    e = expQ.pop_front();
    if (got) begin
      checkOutput("predSum", longint'(o_pred_sum), e.sum);
      checkOutput("predTaken", o_pred_taken, e.taken);
      checkOutput("predIndex", o_pred_index, e.idx);
      checkOutput("predHistory", o_pred_history, e.hist);
      for (int c = 0; c < holdCycles; c++) begin
        i_res_valid = 1'b1;
        i_res_taken = 1'($urandom_range(0, 1));
        for (int k = 0; k < 65; k++) begin
          rowBuf[k] = int'($urandom_range(0, 255)) - 128;
          mWeights[e.idx][k] = rowBuf[k];
        end
        i_upd_valid = 1'b1;
        i_upd_index = e.idx;
        loadUpdWeights();
        mGhr = {mGhr[62:0], i_res_taken};
        @(posedge clk);
        #1 i_res_valid = 1'b0;
        i_upd_valid = 1'b0;
        @(negedge clk);
        checkOutput("holdValid", o_pred_valid, 1);
        checkOutput("holdReqReady", o_req_ready, 0);
        checkOutput("holdSum", longint'(o_pred_sum), e.sum);
        checkOutput("holdTaken", o_pred_taken, e.taken);
        checkOutput("holdIndex", o_pred_index, e.idx);
        checkOutput("holdHistory", o_pred_history, e.hist);
      end
      // A request presented on the handshake edge must not be taken.
      i_pred_ready = 1'b1;
      i_req_valid  = 1'b1;
      i_req_pc     = 32'h0;
      @(posedge clk);
      #1 i_pred_ready = 1'b0;
      i_req_valid = 1'b0;
      @(negedge clk);
      checkOutput("noReaccept", o_req_ready, 1);
      checkOutput("validDrop", o_pred_valid, 0);
      checkOutput("idleSumHeld", longint'(o_pred_sum), e.sum);
    end
  endtask

  initial begin
    i_req_valid   = 1'b0;
    i_req_pc      = '0;
    i_pred_ready  = 1'b0;
    i_res_valid   = 1'b0;
    i_res_taken   = 1'b0;
    i_upd_valid   = 1'b0;
    i_upd_index   = '0;
    i_upd_weights = '0;
    mGhr          = '0;
    for (int p = 0; p < 64; p++)
      for (int k = 0; k < 65; k++) mWeights[p][k] = 0;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstReqReady", o_req_ready, 1);
    checkOutput("rstPredValid", o_pred_valid, 0);
    checkOutput("rstPredSum", longint'(o_pred_sum), 0);
    checkOutput("rstPredTaken", o_pred_taken, 0);
    checkOutput("rstPredIndex", o_pred_index, 0);
    checkOutput("rstPredHistory", o_pred_history, 0);

    $display("[TB] zero weights, pc=0x100");
    applyStimulus(32'h0000_0100, 0, 0, 1);
    collectPrediction(10, -1, 0, 0);

    $display("[TB] row 0 all +1 with all-ones and all-zeros history");
    for (int k = 0; k < 65; k++) rowBuf[k] = 1;
    writeRow(6'd0);
    setGhr('1);
    applyStimulus(32'h0000_0000, 0, 0, 1);
    collectPrediction(10, -1, 0, 0);
    setGhr('0);
    applyStimulus(32'h0000_0000, 0, 0, 1);
    collectPrediction(10, -1, 0, 0);

    $display("[TB] row 3 all -128, zero history");
    for (int k = 0; k < 65; k++) rowBuf[k] = -128;
    writeRow(6'd3);
    applyStimulus(32'h0000_000C, 0, 0, 1);
    collectPrediction(10, -1, 0, 0);

    $display("[TB] random row 5, random history, high pc bits set");
    for (int k = 0; k < 65; k++) rowBuf[k] = int'($urandom_range(0, 255)) - 128;
    writeRow(6'd5);
    setGhr({$urandom, $urandom});
    applyStimulus(32'hABC0_0014, 0, 0, 1);
    collectPrediction(10, -1, 0, 0);

    $display("[TB] write to active row during chunk 4");
    applyStimulus(32'h0000_0014, 0, 0, 1);
    collectPrediction(15, 4, 2, 0);

    $display("[TB] resolve on accept edge, then held prediction under traffic");
    setGhr('0);
    applyStimulus(32'h0000_000C, 1, 1, 1);
    collectPrediction(10, -1, 0, 0);
    applyStimulus(32'h0000_000C, 0, 0, 1);
    collectPrediction(10, -1, 0, 5);

    $display("[TB] reset in the middle of accumulation");
    applyStimulus(32'h0000_0014, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    mGhr = '0;
    for (int p = 0; p < 64; p++)
      for (int k = 0; k < 65; k++) mWeights[p][k] = 0;
    @(negedge clk);
    checkOutput("midRstReqReady", o_req_ready, 1);
    seenValid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (o_pred_valid) seenValid = 1'b1;
    end
    checkOutput("abandonedPred", seenValid, 0);
    applyStimulus(32'h0000_0014, 0, 0, 1);
    collectPrediction(10, -1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/perceptron_predictor.md
PERCEPTRON_PREDICTOR -- requirements
Module: perceptron_predictor

Interface
REQ-001 Parameter PERCEPTRON_NUMBER, default 64: rows in the weight table.
REQ-002 Parameter WEIGHT_NUMBER, default 65: weights per row; weight 0 is the bias.
REQ-003 Parameter WIDTH, default 8: signed weight width.
REQ-004 Parameter HISTORY_SIZE, default 64: global history bits; equals WEIGHT_NUMBER-1.
REQ-005 Parameter LANES, default 8: weights accumulated per cycle.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 req_valid  in  1  prediction request.
REQ-009 req_pc  in  32  branch PC.
REQ-010 req_ready  out  1  request accepted when req_valid && req_ready.
REQ-011 pred_valid  out  1  prediction available.
REQ-012 pred_ready  in  1  consumer takes the prediction when pred_valid && pred_ready.
REQ-013 pred_taken  out  1  predicted direction.
REQ-014 pred_sum  out  SUM_WIDTH  signed perceptron output, passed to the trainer for its threshold test.
REQ-015 pred_index  out  clog2(PERCEPTRON_NUMBER)  selected row.
REQ-016 pred_history  out  HISTORY_SIZE  history snapshot used for this prediction.
REQ-017 res_valid, res_taken  in  1 each  resolved branch outcome from execute.
REQ-018 upd_valid  in  1  row write from the trainer.
REQ-019 upd_index  in  clog2(PERCEPTRON_NUMBER)  row to write.
REQ-020 upd_weights  in  WEIGHT_NUMBER x WIDTH signed  new row contents.

Function
REQ-021 The row index SHALL be req_pc[clog2(PERCEPTRON_NUMBER)+1:2].
REQ-022 The sum SHALL equal w[0] plus, for i=1..HISTORY_SIZE, +w[i] if history[i-1] is 1, else -w[i].
REQ-023 SUM_WIDTH SHALL be WIDTH+clog2(WEIGHT_NUMBER)+1 (16 at defaults); the arithmetic is signed and cannot overflow.
REQ-024 The FSM SHALL have three states: IDLE, ACCUM and DONE; req_ready=1 only in IDLE.
REQ-025 On an accepted request, the block SHALL latch the index and the current GHR as the snapshot, clear the sum and the chunk counter, and go to ACCUM.
REQ-026 In ACCUM, each cycle SHALL add the LANES weights of chunk c (indices c*LANES..c*LANES+LANES-1); indices >= WEIGHT_NUMBER contribute 0.
REQ-027 After the last chunk (NCHUNK=ceil(WEIGHT_NUMBER/LANES)=9), the FSM SHALL go to DONE; pred_valid rises exactly NCHUNK+1 edges after the accept edge when no restart occurs.
REQ-028 In DONE, pred_valid=1 and pred_taken=(pred_sum>=0); all pred_* outputs SHALL hold stable until pred_ready.
REQ-029 DONE && pred_ready SHALL go to IDLE, with no same-cycle re-accept.
REQ-030 upd_valid SHALL write the full row at the edge, in any state.
REQ-031 An upd_valid to the row being accumulated while in ACCUM SHALL restart accumulation: chunk counter 0, sum 0, snapshot kept.
REQ-032 An update during DONE SHALL NOT change the held outputs.
REQ-033 res_valid SHALL shift the GHR: ghr <= {ghr[HISTORY_SIZE-2:0], res_taken}.
REQ-034 When res_valid and the accept fall on the same edge, the snapshot SHALL be the pre-shift GHR.
REQ-035 In IDLE, pred_valid SHALL be 0; pred_taken, pred_sum, pred_index and pred_history hold their last values.

Reset
REQ-036 On rst_n=0 at an edge: FSM to IDLE; GHR, sum, chunk counter, pred_sum, pred_index, pred_history and pred_taken to 0; pred_valid 0; all weights 0.
REQ-037 A reset mid-ACCUM or mid-DONE SHALL abandon the prediction without emitting it.
REQ-038 In the cycle after reset, req_ready=1.

Structure
REQ-039 The parameter defaults, the state enum and the SUM_WIDTH/NCHUNK constants SHALL live in a shared package, bp_perceptron_pkg.
REQ-040 One sub-module, perceptron_chunk_adder, SHALL be combinational: LANES weights, LANES history bits and a bias flag in, a signed partial sum out.

Verification
REQ-041 After reset, accept pc=0x100 -> pred_valid at edge +10, pred_sum=0, pred_taken=1, pred_index=0.
REQ-042 Write row 0 with all weights +1, GHR all ones, request pc=0x0 -> pred_sum=65, taken=1; with GHR all zeros -> pred_sum=-63, taken=0.
REQ-043 Row with every weight -128 and GHR=0 -> pred_sum=+8064 (16-bit, no overflow).
REQ-044 Write to the active row at chunk 4 -> pred_valid delayed to 5+10 edges after accept, and the sum reflects the new weights only.
REQ-045 res_valid=1, res_taken=1 on the accept edge -> pred_history equals the old GHR; a next request sees bit 0 = 1.
REQ-046 Hold pred_ready=0 for 5 cycles while applying res/upd traffic -> pred_* outputs are stable; req_ready=0 throughout.
